// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and its line filter.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_DATA,
    S_ACK_CHK,
    S_WAIT_IDLE,
    S_FAIL,
    S_DONE
  } state_t;

  localparam logic [1:0] E_OK        = 2'd0;
  localparam logic [1:0] E_START_TO  = 2'd1;
  localparam logic [1:0] E_PACKET_TO = 2'd2;
  localparam logic [1:0] E_NOACK     = 2'd3;

  // Bits shifted after the start bit: data[7:0], odd parity, stop.
  localparam logic [3:0] FRAME_LEN = 4'd10;

  // Frame image sent LSB first: {stop, parity, data}.
  function automatic logic [9:0] build_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_filt.sv
// Two-flop synchronizer, FILT-sample level filter and falling-edge strobe
// for one PS/2 line. Filtered level and synchronizer reset to idle-high.
module ps2_filt #(
  parameter int FILT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_pin,
  output logic o_lvl,
  output logic o_fall
);

  localparam int FCW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [FCW-1:0] F_LAST = FCW'(FILT - 1);

  logic [1:0]     r_sync;
  logic           r_lvl;
  logic           r_fall;
  logic [FCW-1:0] r_cnt;

  // Synchronize, then accept a new level only after FILT consecutive
  // disagreeing samples; the fall strobe coincides with the level dropping.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= 2'b11;
      r_lvl  <= 1'b1;
      r_fall <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_pin};
      r_fall <= 1'b0;
      if (r_sync[1] == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == F_LAST) begin
        r_lvl  <= r_sync[1];
        r_fall <= r_lvl;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_lvl  = r_lvl;
  assign o_fall = r_fall;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send,
// shifts one byte plus odd parity and stop on device clock falls, then
// checks the device ACK. Drives open-drain enables only.
// Handshake: start is a one-cycle request honoured only when idle (busy=0);
// data is captured with it. done is a one-cycle strobe; error holds the
// outcome from done until the next accepted start.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int T_INHIBIT   = 3000,
  parameter int T_START_TO  = 375000,
  parameter int T_PACKET_TO = 50000,
  parameter int FILT        = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps_clk_i,
  input  logic       ps_dat_i,
  output logic       ps_clk_oe,
  output logic       ps_dat_oe,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic [1:0] error,
  output state_t     dbg_state
);

  localparam int MAXP_A = (T_INHIBIT > T_START_TO) ? T_INHIBIT : T_START_TO;
  localparam int MAXP   = (MAXP_A > T_PACKET_TO) ? MAXP_A : T_PACKET_TO;
  localparam int CW     = $clog2(MAXP + 1);

  localparam logic [CW-1:0] C_INH_DAT    = CW'(T_INHIBIT - 2);
  localparam logic [CW-1:0] C_INH_LAST   = CW'(T_INHIBIT - 1);
  localparam logic [CW-1:0] C_START_LAST = CW'(T_START_TO - 1);
  localparam logic [CW-1:0] C_PKT_LAST   = CW'(T_PACKET_TO - 1);

  logic w_clk_lvl;
  logic w_clk_fall;
  logic w_dat_lvl;
  logic w_dat_fall_unused;

  state_t        r_state;
  logic          r_clk_oe;
  logic          r_dat_oe;
  logic          r_busy;
  logic          r_done;
  logic [1:0]    r_error;
  logic [9:0]    r_frame;
  logic [3:0]    r_bitcnt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_pkt;
  logic          r_ack_ok;

  ps2_filt #(.FILT(FILT)) u_clk_filt (
    .clock  (clock),
    .reset  (reset),
    .i_pin  (ps_clk_i),
    .o_lvl  (w_clk_lvl),
    .o_fall (w_clk_fall)
  );

  ps2_filt #(.FILT(FILT)) u_dat_filt (
    .clock  (clock),
    .reset  (reset),
    .i_pin  (ps_dat_i),
    .o_lvl  (w_dat_lvl),
    .o_fall (w_dat_fall_unused)
  );

  // Transfer sequencer; every output is a register updated here.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= E_OK;
      r_frame  <= '0;
      r_bitcnt <= '0;
      r_cnt    <= '0;
      r_pkt    <= '0;
      r_ack_ok <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (start) begin
            r_frame  <= build_frame(data);
            r_error  <= E_OK;
            r_busy   <= 1'b1;
            r_clk_oe <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          // Device activity on CLK is irrelevant here; the count is fixed.
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_INH_DAT) r_dat_oe <= 1'b1;
          if (r_cnt == C_INH_LAST) begin
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (r_cnt == C_START_LAST) begin
            r_error  <= E_START_TO;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_state  <= S_FAIL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            // A fall in the first REQ cycle is a leftover of the inhibit.
            if (w_clk_fall && (r_cnt != '0)) begin
              r_dat_oe <= ~r_frame[0];
              r_bitcnt <= 4'd1;
              r_pkt    <= '0;
              r_state  <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (r_pkt >= C_PKT_LAST) begin
            r_error  <= E_PACKET_TO;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_state  <= S_FAIL;
          end else begin
            r_pkt <= r_pkt + 1'b1;
            if (w_clk_fall) begin
              if (r_bitcnt == FRAME_LEN) begin
                // Fall after the stop bit: device should hold DAT low now.
                r_ack_ok <= ~w_dat_lvl;
                r_dat_oe <= 1'b0;
                r_state  <= S_ACK_CHK;
              end else begin
                r_dat_oe <= ~r_frame[r_bitcnt];
                r_bitcnt <= r_bitcnt + 1'b1;
              end
            end
          end
        end
        S_ACK_CHK: begin
          r_pkt <= r_pkt + 1'b1;
          if (r_ack_ok) begin
            r_state <= S_WAIT_IDLE;
          end else begin
            r_error  <= E_NOACK;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_state  <= S_FAIL;
          end
        end
        S_WAIT_IDLE: begin
          if (r_pkt >= C_PKT_LAST) begin
            r_error  <= E_PACKET_TO;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_state  <= S_FAIL;
          end else begin
            r_pkt <= r_pkt + 1'b1;
            if (w_clk_lvl && w_dat_lvl) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end
          end
        end
        S_FAIL: begin
          r_clk_oe <= 1'b0;
          r_dat_oe <= 1'b0;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ps_clk_oe = r_clk_oe;
  assign ps_dat_oe = r_dat_oe;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with a behavioural PS/2 device on the pins.
// Timing parameters are scaled down so every scenario runs quickly.
module tb_ps2_tx;
  import ps2_pkg::*;

  localparam int TI = 30;
  localparam int TS = 600;
  localparam int TP = 800;
  localparam int FL = 4;
  localparam int H  = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps_clk_i, ps_dat_i, ps_clk_oe, ps_dat_oe;
  logic       busy, done;
  logic [1:0] error;
  state_t     dbg_state;

  int vec_cnt = 0;
  int miss_cnt = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int d0 = 0;
  int busy_err = 0;
  int inh_run = 0;
  int last_inh = 0;
  int first_fall_cyc = 0;
  bit xfer_active = 1'b0;
  logic [1:0] last_err = 2'd0;
  logic [1:0] oe_at_done = 2'd0;
  logic [9:0] dev_bits;

  assign ps_clk_i = ps_clk_oe ? 1'b0 : dev_clk;
  assign ps_dat_i = ps_dat_oe ? 1'b0 : dev_dat;

  ps2_tx #(.T_INHIBIT(TI), .T_START_TO(TS), .T_PACKET_TO(TP), .FILT(FL)) dut (
    .clock     (clock),
    .reset     (reset),
    .ps_clk_i  (ps_clk_i),
    .ps_dat_i  (ps_dat_i),
    .ps_clk_oe (ps_clk_oe),
    .ps_dat_oe (ps_dat_oe),
    .start     (start),
    .data      (data),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
  );

  // clock/reset: 25 MHz
  always #20 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt + 1);
    $fatal(1, "watchdog");
  end

  // monitors sampled away from the active edge
  always @(negedge clock) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      last_err = error;
      oe_at_done = {ps_clk_oe, ps_dat_oe};
      xfer_active = 1'b0;
    end else if (xfer_active && !busy) begin
      busy_err++;
    end
    if (ps_clk_oe) inh_run++;
    else if (inh_run != 0) begin
      last_inh = inh_run;
      inh_run = 0;
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send(input logic [7:0] b);
    @(negedge clock);
    start = 1'b1;
    data  = b;
    d0    = done_cnt;
    @(negedge clock);
    start = 1'b0;
    xfer_active = 1'b1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (!ps_clk_oe && ps_dat_oe) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Device: generates nfall clock periods, samples DAT on each rising edge,
  // optionally pulls DAT low before the 11th fall as ACK.
  task automatic dev_clock(input string tag, input int nfall, input bit do_ack, input int glitch_at);
    bit ok;
    dev_bits = '0;
    wait_req(ok);
    check_vec({tag, "_req"}, 32'(ok), 32'd1);
    if (ok) begin
      repeat (10) @(negedge clock);
      for (int i = 0; i < nfall && i < 10; i++) begin
        dev_clk = 1'b0;
        if (i == 0) first_fall_cyc = cyc;
        repeat (H) @(negedge clock);
        dev_clk = 1'b1;
        dev_bits[i] = ps_dat_i;
        if (i == glitch_at) begin
          repeat (5) @(negedge clock);
          dev_clk = 1'b0;
          repeat (2) @(negedge clock);
          dev_clk = 1'b1;
          repeat (H - 7) @(negedge clock);
        end else begin
          repeat (H) @(negedge clock);
        end
      end
      if (nfall > 10) begin
        dev_dat = do_ack ? 1'b0 : 1'b1;
        repeat (H) @(negedge clock);
        dev_clk = 1'b0;
        repeat (H) @(negedge clock);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        repeat (H) @(negedge clock);
      end
    end
  endtask

  task automatic finish_xfer(input string tag, input logic [1:0] exp_err);
    int n = 0;
    while (done_cnt == d0 && n < 4000) begin
      @(negedge clock);
      n++;
    end
    check_vec({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    repeat (20) @(negedge clock);
    check_vec({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    check_vec({tag, "_err"}, 32'(last_err), 32'(exp_err));
  endtask

  initial begin
    int  n;
    bit  seen;
    int  lat;

    // reset state
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_vec("rst_clk_oe", 32'(ps_clk_oe), 32'd0);
    check_vec("rst_dat_oe", 32'(ps_dat_oe), 32'd0);
    check_vec("rst_busy",   32'(busy),      32'd0);
    check_vec("rst_done",   32'(done),      32'd0);
    check_vec("rst_error",  32'(error),     32'd0);

    // 0xED with ACK: data bits 1,0,1,1,0,1,1,1 then parity 1, stop 1
    busy_err = 0;
    send(8'hED);
    dev_clock("ed", 11, 1'b1, -1);
    finish_xfer("ed", E_OK);
    check_vec("ed_inhibit_len", 32'(last_inh), 32'(TI));
    check_vec("ed_bits", 32'(dev_bits), 32'h3ED);
    check_vec("ed_busy_held", 32'(busy_err), 32'd0);

    // 0xF4 (parity 0) with a stray start pulse of 0x00 mid-transfer
    send(8'hF4);
    fork
      dev_clock("f4", 11, 1'b1, -1);
      begin
        repeat (200) @(negedge clock);
        start = 1'b1;
        data  = 8'h00;
        @(negedge clock);
        start = 1'b0;
      end
    join
    finish_xfer("f4", E_OK);
    check_vec("f4_bits", 32'(dev_bits), 32'h2F4);

    // 0x00: parity 1
    send(8'h00);
    dev_clock("z0", 11, 1'b1, -1);
    finish_xfer("z0", E_OK);
    check_vec("z0_bits", 32'(dev_bits), 32'h300);

    // device never clocks: REQ lasts TS cycles, FAIL one, then done
    send(8'h12);
    wait_req(seen);
    check_vec("sto_req", 32'(seen), 32'd1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < TS + 100) begin
      @(negedge clock);
      n++;
      if (done) begin
        seen = 1'b1;
        check_vec("sto_err", 32'(error), 32'(E_START_TO));
        check_vec("sto_oe", 32'({ps_clk_oe, ps_dat_oe}), 32'd0);
      end
    end
    check_vec("sto_latency", 32'(n), 32'(TS + 1));
    repeat (5) @(negedge clock);

    // device stops after 5 falls: packet timeout
    send(8'h5A);
    dev_clock("pto", 5, 1'b1, -1);
    finish_xfer("pto", E_PACKET_TO);
    lat = done_cyc - first_fall_cyc;
    check_vec("pto_latency_window", 32'(lat >= TP && lat <= TP + 12), 32'd1);
    check_vec("pto_oe", 32'(oe_at_done), 32'd0);

    // device leaves DAT high at the ACK clock
    send(8'hFF);
    dev_clock("nak", 11, 1'b0, -1);
    finish_xfer("nak", E_NOACK);

    // reset in DATA
    send(8'h00);
    dev_clock("rst", 3, 1'b1, -1);
    check_vec("rst_mid_state", 32'(dbg_state), 32'(S_DATA));
    check_vec("rst_mid_dat_oe_pre", 32'(ps_dat_oe), 32'd1);
    check_vec("rst_mid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    xfer_active = 1'b0;
    @(negedge clock);
    check_vec("rst_mid_clk_oe", 32'(ps_clk_oe), 32'd0);
    check_vec("rst_mid_dat_oe", 32'(ps_dat_oe), 32'd0);
    check_vec("rst_mid_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (100) @(negedge clock);
    check_vec("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);

    // 2-cycle CLK glitch during a high phase is filtered out
    send(8'hA5);
    dev_clock("glt", 11, 1'b1, 3);
    finish_xfer("glt", E_OK);
    check_vec("glt_bits", 32'(dev_bits), 32'h3A5);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
